// File: rtl/seg_scan_capture.sv
// Captures the hex value shown on a scanned, active-low 8-digit 7-segment bus.
// Each digit is accepted after STABLE_CYCLES identical synchronised samples.
module seg_scan_capture #(
  parameter int unsigned STABLE_CYCLES = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [7:0]  dataout_in,
  input  logic [7:0]  en_in,
  input  logic        clr_err,
  output logic [31:0] digits,
  output logic [7:0]  digit_valid,
  output logic [7:0]  err_flags,
  output logic        frame_done
);

  localparam logic [7:0] StableCnt = 8'(STABLE_CYCLES);

  logic [7:0]  seg_s1_q, seg_s2_q, en_s1_q, en_s2_q;
  logic [7:0]  seg_p_q, en_p_q;
  logic [7:0]  cnt_q, cnt_d;
  logic [7:0]  mask_q, mask_d;
  logic [31:0] digits_d;
  logic [7:0]  valid_d, err_d;
  logic [7:0]  sel;
  logic        one_hot, pair_same, cap;
  logic [4:0]  dec;

  // Returns {code_ok, nibble}; dp is not part of the pattern.
  function automatic logic [4:0] decode(input logic [6:0] s);
    logic [4:0] r;
    case (s)
      7'h40:   r = {1'b1, 4'h0};
      7'h79:   r = {1'b1, 4'h1};
      7'h24:   r = {1'b1, 4'h2};
      7'h30:   r = {1'b1, 4'h3};
      7'h19:   r = {1'b1, 4'h4};
      7'h12:   r = {1'b1, 4'h5};
      7'h02:   r = {1'b1, 4'h6};
      7'h78:   r = {1'b1, 4'h7};
      7'h00:   r = {1'b1, 4'h8};
      7'h18:   r = {1'b1, 4'h9};
      7'h08:   r = {1'b1, 4'hA};
      7'h03:   r = {1'b1, 4'hB};
      7'h46:   r = {1'b1, 4'hC};
      7'h21:   r = {1'b1, 4'hD};
      7'h06:   r = {1'b1, 4'hE};
      7'h0E:   r = {1'b1, 4'hF};
      default: r = 5'b0_0000;
    endcase
    return r;
  endfunction

  always_comb begin
    sel       = ~en_s2_q;
    one_hot   = (sel != 8'h00) && ((sel & (sel - 8'd1)) == 8'h00);
    pair_same = (en_s2_q == en_p_q) && (seg_s2_q == seg_p_q);
    dec       = decode(seg_s2_q[6:0]);

    if (!one_hot) begin
      cnt_d = 8'd0;
    end else if (!pair_same || cnt_q == 8'd0) begin
      cnt_d = 8'd1;
    end else if (cnt_q < StableCnt) begin
      cnt_d = cnt_q + 8'd1;
    end else begin
      cnt_d = cnt_q;
    end

    // Fires once per dwell: only on the transition into saturation.
    cap = one_hot && (cnt_d == StableCnt) && (cnt_q != StableCnt);

    digits_d = digits;
    valid_d  = digit_valid;
    err_d    = clr_err ? 8'h00 : err_flags;
    // A full mask is consumed by this edge's frame_done pulse.
    mask_d   = (mask_q == 8'hFF) ? 8'h00 : mask_q;

    for (int i = 0; i < 8; i++) begin
      if (cap && sel[i]) begin
        if (dec[4]) begin
          digits_d[4*i +: 4] = dec[3:0];
          valid_d[i]         = 1'b1;
          mask_d[i]          = 1'b1;
        end else begin
          err_d[i] = 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      seg_s1_q    <= 8'hFF;
      seg_s2_q    <= 8'hFF;
      en_s1_q     <= 8'hFF;
      en_s2_q     <= 8'hFF;
      seg_p_q     <= 8'hFF;
      en_p_q      <= 8'hFF;
      cnt_q       <= 8'd0;
      mask_q      <= 8'h00;
      digits      <= 32'h0;
      digit_valid <= 8'h00;
      err_flags   <= 8'h00;
      frame_done  <= 1'b0;
    end else begin
      seg_s1_q    <= dataout_in;
      seg_s2_q    <= seg_s1_q;
      en_s1_q     <= en_in;
      en_s2_q     <= en_s1_q;
      seg_p_q     <= seg_s2_q;
      en_p_q      <= en_s2_q;
      cnt_q       <= cnt_d;
      mask_q      <= mask_d;
      digits      <= digits_d;
      digit_valid <= valid_d;
      err_flags   <= err_d;
      frame_done  <= (mask_q == 8'hFF);
    end
  end

endmodule

// File: tb/tb_seg_scan_capture.sv
// Directed bench for seg_scan_capture with a reference model feeding a scoreboard queue.
module tb_seg_scan_capture;

  localparam int unsigned STABLE = 4;

  logic        clk = 1'b0;
  logic        rst;
  logic [7:0]  dataout_in, en_in;
  logic        clr_err;
  logic [31:0] digits;
  logic [7:0]  digit_valid, err_flags;
  logic        frame_done;

  seg_scan_capture #(.STABLE_CYCLES(STABLE)) dut (
    .clk         (clk),
    .rst         (rst),
    .dataout_in  (dataout_in),
    .en_in       (en_in),
    .clr_err     (clr_err),
    .digits      (digits),
    .digit_valid (digit_valid),
    .err_flags   (err_flags),
    .frame_done  (frame_done)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [31:0] d;
    logic [7:0]  v;
    logic [7:0]  e;
  } exp_t;

  exp_t sb[$];
  int passed = 0, failed = 0, total = 0;
  int fd_cnt = 0;

  logic [31:0] exp_digits = 32'h0;
  logic [7:0]  exp_valid = 8'h00, exp_err = 8'h00, exp_mask = 8'h00;
  int          exp_frames = 0;

  logic [6:0] code_tbl [16] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
                                7'h00, 7'h18, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};

  always @(negedge clk) if (frame_done === 1'b1) fd_cnt++;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    assert (got === exp) passed++;
    else begin
      failed++;
      $error("FAIL %s: observed %h expected %h", tag, got, exp);
    end
  endtask

  task automatic model_reset();
    exp_digits = 32'h0;
    exp_valid  = 8'h00;
    exp_err    = 8'h00;
    exp_mask   = 8'h00;
  endtask

  task automatic model_capture(input logic [7:0] en, input logic [7:0] seg);
    int zeros = 0, idx = 0, val = -1;
    for (int i = 0; i < 8; i++) if (!en[i]) begin zeros++; idx = i; end
    if (zeros != 1) return;
    for (int c = 0; c < 16; c++) if (code_tbl[c] == seg[6:0]) val = c;
    if (val < 0) begin
      exp_err[idx] = 1'b1;
    end else begin
      exp_digits[4*idx +: 4] = 4'(val);
      exp_valid[idx] = 1'b1;
      exp_mask[idx]  = 1'b1;
      if (exp_mask == 8'hFF) begin
        exp_frames++;
        exp_mask = 8'h00;
      end
    end
  endtask

  task automatic idle(input int n);
    en_in = 8'hFF;
    dataout_in = 8'hFF;
    repeat (n) @(negedge clk);
  endtask

  task automatic push_exp();
    sb.push_back('{d: exp_digits, v: exp_valid, e: exp_err});
  endtask

  task automatic dwell(input logic [7:0] en, input logic [7:0] seg, input int n);
    en_in = en;
    dataout_in = seg;
    repeat (n) @(negedge clk);
    if (n >= int'(STABLE)) model_capture(en, seg);
    idle(4);
    push_exp();
  endtask

  task automatic sb_check(input string tag);
    exp_t e;
    if (sb.size() == 0) begin
      check({tag, "_sb_empty"}, 32'd0, 32'd1);
      return;
    end
    e = sb.pop_front();
    check({tag, "_digits"}, digits, e.d);
    check({tag, "_valid"}, {24'h0, digit_valid}, {24'h0, e.v});
    check({tag, "_err"}, {24'h0, err_flags}, {24'h0, e.e});
  endtask

  logic [7:0] scan_a [8] = '{8'hC0, 8'hF9, 8'hA4, 8'hB0, 8'h99, 8'h92, 8'h82, 8'hF8};
  logic [7:0] scan_b [8] = '{8'h8E, 8'h86, 8'hA1, 8'hC6, 8'h83, 8'h88, 8'h98, 8'h80};

  initial begin
    int lat;
    logic [7:0] en;
    rst = 1'b0;
    clr_err = 1'b0;
    en_in = 8'hFF;
    dataout_in = 8'hFF;
    #3;
    check("rst_digits", digits, 32'h0);
    check("rst_valid", {24'h0, digit_valid}, 32'h0);
    check("rst_err", {24'h0, err_flags}, 32'h0);
    check("rst_frame", {31'h0, frame_done}, 32'h0);
    repeat (2) @(negedge clk);
    rst = 1'b1;
    idle(2);

    // Minimum-hold and too-short dwells on digit 2.
    dwell(8'hFB, 8'h88, STABLE + 1);
    sb_check("hold_a");
    check("hold_a_nibble", {28'h0, digits[11:8]}, 32'hA);
    dwell(8'hFB, 8'hC0, STABLE - 2);
    sb_check("short");

    for (int i = 0; i < 8; i++) begin
      en = ~(8'd1 << i);
      dwell(en, scan_a[i], 20);
      sb_check($sformatf("scan_a%0d", i));
    end
    check("scan_a_value", digits, 32'h76543210);
    check("scan_a_frames", 32'(fd_cnt), 32'(exp_frames));

    // Pin-to-output latency on digit 0.
    en_in = 8'hFE;
    dataout_in = 8'hF9;
    lat = 0;
    for (int k = 1; k <= 20; k++) begin
      @(posedge clk);
      #1;
      if (digits[3:0] == 4'h1) begin
        lat = k;
        break;
      end
    end
    check("latency", 32'(lat), 32'(STABLE + 2));
    @(negedge clk);
    model_capture(8'hFE, 8'hF9);
    idle(4);
    push_exp();
    sb_check("latency_state");

    // Blank pattern flags an error; clr_err clears it.
    dwell(8'hF7, 8'hFF, 10);
    sb_check("blank");
    clr_err = 1'b1;
    @(negedge clk);
    clr_err = 1'b0;
    exp_err = 8'h00;
    check("clr_err", {24'h0, err_flags}, {24'h0, exp_err});

    // Error capture on the same edge as clr_err keeps its bit.
    dwell(8'hF7, 8'hFF, 10);
    sb_check("blank2");
    en_in = 8'hEF;
    dataout_in = 8'hFF;
    repeat (STABLE + 1) @(negedge clk);
    clr_err = 1'b1;
    @(negedge clk);
    clr_err = 1'b0;
    exp_err = 8'h00;
    model_capture(8'hEF, 8'hFF);
    idle(4);
    check("clr_vs_err", {24'h0, err_flags}, {24'h0, exp_err});

    dwell(8'hF3, 8'hC0, 50);
    sb_check("two_low");

    // Capture digit 5, then reset on the following cycle.
    en_in = 8'hDF;
    dataout_in = 8'h88;
    repeat (STABLE + 2) @(negedge clk);
    check("pre_rst_d5", {28'h0, digits[23:20]}, 32'hA);
    @(posedge clk);
    #1 rst = 1'b0;
    #1;
    model_reset();
    check("async_rst_out", {digits, digit_valid, err_flags} == 48'h0 ? 32'd0 : 32'd1, 32'd0);
    check("async_rst_frame", {31'h0, frame_done}, 32'h0);
    @(negedge clk);
    rst = 1'b1;
    idle(3);

    // Reset during a dwell restarts the stability run.
    en_in = 8'hFE;
    dataout_in = 8'hF9;
    repeat (3) @(negedge clk);
    #1 rst = 1'b0;
    #2 rst = 1'b1;
    repeat (3) @(negedge clk);
    check("mid_rst_nocap", {24'h0, digit_valid}, 32'h0);
    repeat (4) @(negedge clk);
    model_capture(8'hFE, 8'hF9);
    idle(4);
    push_exp();
    sb_check("mid_rst_cap");

    for (int pass = 0; pass < 2; pass++) begin
      for (int i = 0; i < 8; i++) begin
        en = ~(8'd1 << i);
        dwell(en, scan_b[i], 8);
        sb_check($sformatf("scan_b%0d_%0d", pass, i));
      end
    end
    check("scan_b_value", digits, 32'h89ABCDEF);
    check("frames_total", 32'(fd_cnt), 32'(exp_frames));

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL timeout: observed running expected finished");
    $fatal(1, "bench timeout");
  end

endmodule
